// File: rtl/switch_alloc_rr.sv
// Separable input-first round-robin switch allocator: input arbiters pick one output per
// input, output arbiters pick one winner per output, and the grant matrix is registered.
module switch_alloc_rr #(
    parameter int NUM_PORT     = 5,
    parameter int LOG_NUM_PORT = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [NUM_PORT*NUM_PORT-1:0]     reqVector,
    input  logic [NUM_PORT-1:0]              outBusy,
    output logic [NUM_PORT*NUM_PORT-1:0]     allocVector,
    output logic                             allocValid
);

    typedef logic [LOG_NUM_PORT-1:0] ptr_t;

    // [j][k] packing flattens to bit j*NUM_PORT+k, matching reqVector/allocVector
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     w_effReq;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     w_inWin;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     w_col;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     w_colGnt;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     w_grant;
    logic [NUM_PORT-1:0][LOG_NUM_PORT-1:0] w_inPtrNxt;
    logic [NUM_PORT-1:0][LOG_NUM_PORT-1:0] w_outPtrNxt;

    logic [NUM_PORT-1:0][LOG_NUM_PORT-1:0] r_inPtr;
    logic [NUM_PORT-1:0][LOG_NUM_PORT-1:0] r_outPtr;
    logic [NUM_PORT*NUM_PORT-1:0]          r_allocVector;
    logic                                  r_allocValid;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NUM_PORT-1)) ? '0 : p + 1'b1;
    endfunction

    // First set bit at or above ptr, wrapping modulo NUM_PORT; one-hot or zero
    function automatic logic [NUM_PORT-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                                    input ptr_t ptr);
        logic [NUM_PORT-1:0] oh;
        logic                found;
        ptr_t                idx;
        oh    = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!found && req[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
            idx = ptr_inc(idx);
        end
        return oh;
    endfunction

    always_comb begin
        w_effReq    = '0;
        w_inWin     = '0;
        w_col       = '0;
        w_colGnt    = '0;
        w_grant     = '0;
        w_inPtrNxt  = r_inPtr;
        w_outPtrNxt = r_outPtr;
        for (int j = 0; j < NUM_PORT; j++) begin
            w_effReq[j] = reqVector[j*NUM_PORT +: NUM_PORT] & ~outBusy;
            w_inWin[j]  = rr_pick(w_effReq[j], r_inPtr[j]);
        end
        // w_col[k][j] is the transpose of the stage-1 winners
        for (int k = 0; k < NUM_PORT; k++) begin
            for (int j = 0; j < NUM_PORT; j++) w_col[k][j] = w_inWin[j][k];
            w_colGnt[k] = rr_pick(w_col[k], r_outPtr[k]);
            for (int j = 0; j < NUM_PORT; j++) w_grant[j][k] = w_colGnt[k][j];
        end
        // Only granted pairs move pointers; stage-2 losers keep their position
        for (int j = 0; j < NUM_PORT; j++) begin
            for (int k = 0; k < NUM_PORT; k++) begin
                if (w_grant[j][k]) begin
                    w_inPtrNxt[j]  = ptr_inc(ptr_t'(k));
                    w_outPtrNxt[k] = ptr_inc(ptr_t'(j));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inPtr       <= '0;
            r_outPtr      <= '0;
            r_allocVector <= '0;
            r_allocValid  <= 1'b0;
        end else if (en) begin
            r_inPtr       <= w_inPtrNxt;
            r_outPtr      <= w_outPtrNxt;
            r_allocVector <= w_grant;
            r_allocValid  <= |w_grant;
        end
    end

    assign allocVector = r_allocVector;
    assign allocValid  = r_allocValid;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Directed plus random bench for switch_alloc_rr against a pointer-level reference model.
module tb_switch_alloc_rr;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [N*N-1:0] reqVector;
    logic [N-1:0]   outBusy;
    logic [N*N-1:0] allocVector;
    logic           allocValid;

    int nchecks = 0;
    int nerrors = 0;

    int             inPtr[N];
    int             outPtr[N];
    logic [N*N-1:0] exp_alloc;
    logic           exp_valid;

    switch_alloc_rr #(.NUM_PORT(N), .LOG_NUM_PORT(3)) dut (
        .clk(clk), .reset(reset), .en(en), .reqVector(reqVector),
        .outBusy(outBusy), .allocVector(allocVector), .allocValid(allocValid)
    );

    always #5 clk = ~clk;

    function automatic logic [N*N-1:0] model_grant(input logic [N*N-1:0] req,
                                                   input logic [N-1:0] busy);
        int             win[N];
        logic [N*N-1:0] g;
        g = '0;
        for (int j = 0; j < N; j++) begin
            win[j] = -1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (inPtr[j] + i) % N;
                if (req[j*N+k] && !busy[k]) begin
                    win[j] = k;
                    break;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (outPtr[k] + i) % N;
                if (win[j] == k) begin
                    g[j*N+k] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            inPtr[i]  = 0;
            outPtr[i] = 0;
        end
        exp_alloc = '0;
        exp_valid = 1'b0;
    endtask

    task automatic check(input string tag);
        nchecks++;
        assert (allocVector === exp_alloc) else begin
            nerrors++;
            $error("FAIL %s allocVector got %h expected %h", tag, allocVector, exp_alloc);
        end
        nchecks++;
        assert (allocValid === exp_valid) else begin
            nerrors++;
            $error("FAIL %s allocValid got %b expected %b", tag, allocValid, exp_valid);
        end
    endtask

    // Drive one cycle, predict from pre-edge pointers, check 1 time unit after the edge
    task automatic step(input logic [N*N-1:0] req, input logic [N-1:0] busy,
                        input logic e, input string tag);
        logic [N*N-1:0] g;
        reqVector = req;
        outBusy   = busy;
        en        = e;
        g = model_grant(req, busy);
        @(posedge clk);
        #1;
        if (e) begin
            exp_alloc = g;
            exp_valid = |g;
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    if (g[j*N+k]) begin
                        inPtr[j]  = (k + 1) % N;
                        outPtr[k] = (j + 1) % N;
                    end
        end
        check(tag);
    endtask

    // Reset pulsed between clock edges; outputs must clear before the next edge
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check(tag);
        #2 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                logic [N-1:0] col;
                for (int j = 0; j < N; j++) col[j] = allocVector[j*N+i];
                nchecks++;
                assert ($countones(allocVector[i*N +: N]) <= 1 && $countones(col) <= 1) else begin
                    nerrors++;
                    $error("FAIL legality row/col %0d alloc %h", i, allocVector);
                end
            end
        end
    end

    initial begin
        logic [N*N-1:0] r;
        logic [N-1:0]   b;
        reset = 1'b1; en = 1'b0; reqVector = '0; outBusy = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        #4 reset = 1'b0;

        // input 2 -> output 3
        step(25'd1 << 13, 5'b0, 1'b1, "single_2to3");
        nchecks++;
        assert (allocVector === (25'd1 << 13) && inPtr[2] == 4 && outPtr[3] == 3) else begin
            nerrors++;
            $error("FAIL single_const got %h expected %h", allocVector, 25'd1 << 13);
        end
        async_reset("reset_a");

        // everyone wants output 0: grants rotate 0,1,2,3,4,0
        for (int c = 0; c < 6; c++) step(25'h0108421, 5'b0, 1'b1, "hotspot_out0");
        async_reset("reset_b");

        // input 1 wants outputs 0 and 4
        for (int c = 0; c < 3; c++) step((25'd1 << 5) | (25'd1 << 9), 5'b0, 1'b1, "in1_rr");
        async_reset("reset_c");

        // busy output masks the request, then releases
        step(25'd1 << 2, 5'b00100, 1'b1, "busy_mask");
        step(25'd1 << 2, 5'b00000, 1'b1, "busy_clear");

        // full matrix with en low for three cycles
        step('1, 5'b0, 1'b1, "full_a");
        step('1, 5'b0, 1'b1, "full_b");
        for (int c = 0; c < 3; c++) step('1, 5'b0, 1'b0, "en_hold");
        step('1, 5'b0, 1'b1, "full_resume");
        step('0, 5'b0, 1'b1, "empty");
        step('1, 5'b11111, 1'b1, "all_busy");

        for (int c = 0; c < 300; c++) begin
            r = 25'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 25'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            step(r, b, ($urandom_range(0, 5) != 0), "random");
            if (c == 150) async_reset("reset_mid");
        end

        step('1, 5'b0, 1'b1, "pre_reset");
        async_reset("reset_traffic");
        step('1, 5'b0, 1'b1, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
